// File: rtl/alu_acc_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU/shifter and accumulator between two requesters.
// Optional build macro ACC_CHAIN_EN: a winner may take operand A and carry-in from the accumulator.
module alu_acc_arbiter #(
  parameter int WIDTH     = 4,
  parameter int SETTLE    = 1,
  parameter int INIT_PRIO = 0
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic             req0,
  input  logic             req1,
  input  logic [3:0]       mode0,
  input  logic [3:0]       mode1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] b1,
  input  logic             cin0,
  input  logic             cin1,
`ifdef ACC_CHAIN_EN
  input  logic             use_acc0,
  input  logic             use_acc1,
  input  logic [WIDTH-1:0] acc_q,
  input  logic             acc_cbf,
`endif
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [3:0]       alu_mode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_of,
  output logic             acc_load,
  output logic [WIDTH:0]   acc_d,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] res,
  output logic             of,
  output logic [1:0]       dbg_state
);

  // Handshake: a requester raises reqN and holds it until the falling edge where
  // doneN is seen; gntN marks ownership from the grant edge to RESP exit, and
  // doneN/rsp_valid are single-cycle pulses carrying res/of/rsp_id.
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_LOAD, S_RESP} state_t;

  localparam int       SETTLE_EFF = (SETTLE < 1) ? 1 : ((SETTLE > 7) ? 7 : SETTLE);
  localparam logic [2:0] CNT_LAST = 3'(SETTLE_EFF - 1);
  localparam logic     PRIO_RST   = (INIT_PRIO != 0);

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             done0_q, done0_d, done1_q, done1_d;
  logic [3:0]       alu_mode_q, alu_mode_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic             alu_cin_q, alu_cin_d;
  logic             acc_load_q, acc_load_d;
  logic [WIDTH:0]   acc_d_q, acc_d_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             of_q, of_d;
  logic             win;

  always_ff @(negedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= S_IDLE;
      ptr_q       <= PRIO_RST;
      cnt_q       <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      alu_mode_q  <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_cin_q   <= 1'b0;
      acc_load_q  <= 1'b0;
      acc_d_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      res_q       <= '0;
      of_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      alu_mode_q  <= alu_mode_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_cin_q   <= alu_cin_d;
      acc_load_q  <= acc_load_d;
      acc_d_q     <= acc_d_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      res_q       <= res_d;
      of_q        <= of_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt0_d      = gnt0_q;
    gnt1_d      = gnt1_q;
    done0_d     = done0_q;
    done1_d     = done1_q;
    alu_mode_d  = alu_mode_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_cin_d   = alu_cin_q;
    acc_load_d  = acc_load_q;
    acc_d_d     = acc_d_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    res_d       = res_q;
    of_d        = of_q;
    win         = (req0 && req1) ? ptr_q : req1;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          alu_mode_d = win ? mode1 : mode0;
          alu_a_d    = win ? a1 : a0;
          alu_b_d    = win ? b1 : b0;
          alu_cin_d  = win ? cin1 : cin0;
`ifdef ACC_CHAIN_EN
          if (win ? use_acc1 : use_acc0) begin
            alu_a_d   = acc_q;
            alu_cin_d = acc_cbf;
          end
`endif
          gnt0_d   = ~win;
          gnt1_d   = win;
          rsp_id_d = win;
          ptr_d    = ~win;
          cnt_d    = '0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Operands have been stable SETTLE cycles once the count reaches its last value.
        if (cnt_q == CNT_LAST) begin
          acc_d_d    = {alu_res, alu_of};
          res_d      = alu_res;
          of_d       = alu_of;
          acc_load_d = 1'b1;
          state_d    = S_LOAD;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_LOAD: begin
        acc_load_d  = 1'b0;
        done0_d     = ~rsp_id_q;
        done1_d     = rsp_id_q;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        rsp_valid_d = 1'b0;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign alu_mode  = alu_mode_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_cin   = alu_cin_q;
  assign acc_load  = acc_load_q;
  assign acc_d     = acc_d_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign res       = res_q;
  assign of        = of_q;
  assign dbg_state = state_q;

endmodule
